// File: rtl/hazard_sequencer.sv
//------------------------------------------------------------------------------
// Module      : hazard_sequencer
// Description : Stall/flush/forward controller for the five-stage pipeline.
//               Resolves load-use and branch hazards, selects E-stage operand
//               forwarding, and sequences multi-cycle data-memory waits with
//               timeout detection.
//               Optional performance counters: define HAZARD_PERF_CNT_EN.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module hazard_sequencer #(
   parameter logic [2:0] LOAD_RESULT_SRC = 3'b001,
   parameter int         MEM_TIMEOUT     = 64
) (
   input  logic        iClk,
   input  logic        iRst,
   input  logic [4:0]  iRs1D,
   input  logic [4:0]  iRs2D,
   input  logic [4:0]  iRs1E,
   input  logic [4:0]  iRs2E,
   input  logic [4:0]  iRdE,
   input  logic [2:0]  iResultSrcE,
   input  logic        iRegWriteEnE,
   input  logic        iPCSrcE,
   input  logic [4:0]  iRdM,
   input  logic        iRegWriteEnM,
   input  logic        iMemReqM,
   input  logic        iMemReadyM,
   input  logic [4:0]  iRdW,
   input  logic        iRegWriteEnW,
   output logic        oStallF,
   output logic        oStallD,
   output logic        oStallE,
   output logic        oStallM,
   output logic        oFlushD,
   output logic        oFlushE,
   output logic        oFlushW,
   output logic [1:0]  oForwardAE,
   output logic [1:0]  oForwardBE,
   output logic        oMemTimeout,
   output logic [31:0] oStallCycles,
   output logic [31:0] oFlushCount
);

   localparam int                 c_cnt_w = $clog2(MEM_TIMEOUT + 1);
   localparam logic [c_cnt_w-1:0] c_max   = c_cnt_w'(MEM_TIMEOUT);
   localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(MEM_TIMEOUT - 1);

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_MEM_WAIT = 2'd1,
      ST_ERROR    = 2'd2
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [c_cnt_w-1:0] r_wait_cnt;
   logic [c_cnt_w-1:0] w_wait_cnt_nxt;
   logic               r_timeout;
   logic               w_timeout_nxt;
   logic               w_load_use;

   // A load in E whose destination feeds a D-stage source needs one bubble
   assign w_load_use = (iResultSrcE == LOAD_RESULT_SRC) && iRegWriteEnE &&
                       (iRdE != 5'd0) && ((iRdE == iRs1D) || (iRdE == iRs2D));

   assign oMemTimeout = r_timeout;

   // Operand forwarding; the younger M result wins over W
   always_comb begin
      oForwardAE = 2'b00;
      oForwardBE = 2'b00;
      if (!iRst) begin
         if (iRegWriteEnM && (iRdM != 5'd0) && (iRdM == iRs1E))
            oForwardAE = 2'b10;
         else if (iRegWriteEnW && (iRdW != 5'd0) && (iRdW == iRs1E))
            oForwardAE = 2'b01;
         if (iRegWriteEnM && (iRdM != 5'd0) && (iRdM == iRs2E))
            oForwardBE = 2'b10;
         else if (iRegWriteEnW && (iRdW != 5'd0) && (iRdW == iRs2E))
            oForwardBE = 2'b01;
      end
   end

   // Next-state, wait counter and stall/flush decode
   always_comb begin
      w_state_nxt    = r_state;
      w_wait_cnt_nxt = r_wait_cnt;
      w_timeout_nxt  = r_timeout;
      oStallF        = 1'b0;
      oStallD        = 1'b0;
      oStallE        = 1'b0;
      oStallM        = 1'b0;
      oFlushD        = 1'b0;
      oFlushE        = 1'b0;
      oFlushW        = 1'b0;
      case (r_state)
         ST_RUN: begin
            if (iMemReqM && !iMemReadyM) begin
               // Freeze the whole pipe; a taken branch stays parked in E
               {oStallF, oStallD, oStallE, oStallM, oFlushW} = 5'b11111;
               w_wait_cnt_nxt = c_cnt_w'(1);
               if (MEM_TIMEOUT <= 1) begin
                  w_state_nxt   = ST_ERROR;
                  w_timeout_nxt = 1'b1;
               end else begin
                  w_state_nxt = ST_MEM_WAIT;
               end
            end else if (iPCSrcE) begin
               oFlushD = 1'b1;
               oFlushE = 1'b1;
            end else if (w_load_use) begin
               oStallF = 1'b1;
               oStallD = 1'b1;
               oFlushE = 1'b1;
            end
         end
         ST_MEM_WAIT: begin
            if (!iMemReadyM) begin
               {oStallF, oStallD, oStallE, oStallM, oFlushW} = 5'b11111;
               if (r_wait_cnt >= c_last) begin
                  w_state_nxt    = ST_ERROR;
                  w_timeout_nxt  = 1'b1;
                  w_wait_cnt_nxt = c_max;
               end else begin
                  w_wait_cnt_nxt = r_wait_cnt + 1'b1;
               end
            end else begin
               // Release cycle: hazards are re-evaluated on the next RUN cycle
               w_state_nxt    = ST_RUN;
               w_wait_cnt_nxt = '0;
            end
         end
         ST_ERROR: begin
            {oStallF, oStallD, oStallE, oStallM, oFlushW} = 5'b11111;
            w_timeout_nxt = 1'b1;
         end
         default: begin
            w_state_nxt    = ST_RUN;
            w_wait_cnt_nxt = '0;
         end
      endcase
      // Reset squashes D and E and releases every stall
      if (iRst) begin
         {oStallF, oStallD, oStallE, oStallM, oFlushW} = 5'b00000;
         oFlushD = 1'b1;
         oFlushE = 1'b1;
      end
   end

   // State, wait counter and sticky timeout registers
   always_ff @(posedge iClk) begin
      if (iRst) begin
         r_state    <= ST_RUN;
         r_wait_cnt <= '0;
         r_timeout  <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_wait_cnt <= w_wait_cnt_nxt;
         r_timeout  <= w_timeout_nxt;
      end
   end

`ifdef HAZARD_PERF_CNT_EN
   logic [31:0] r_stall_cycles;
   logic [31:0] r_flush_count;

   // Stall-cycle and hazard-flush counters; reset flushes never reach here
   always_ff @(posedge iClk) begin
      if (iRst) begin
         r_stall_cycles <= 32'd0;
         r_flush_count  <= 32'd0;
      end else begin
         if (oStallF)
            r_stall_cycles <= r_stall_cycles + 32'd1;
         if (oFlushE)
            r_flush_count <= r_flush_count + 32'd1;
      end
   end

   assign oStallCycles = r_stall_cycles;
   assign oFlushCount  = r_flush_count;
`else
   assign oStallCycles = 32'd0;
   assign oFlushCount  = 32'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_hazard_sequencer.sv
//------------------------------------------------------------------------------
// Module      : tb_hazard_sequencer
// Description : Self-checking bench for hazard_sequencer (MEM_TIMEOUT = 4).
//               Honours HAZARD_PERF_CNT_EN when the design is built with it.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_hazard_sequencer;

   localparam int TB_TIMEOUT = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
   logic [2:0]  res_src_e;
   logic        we_e, pcsrc_e, we_m, req_m, rdy_m, we_w;
   logic        stall_f, stall_d, stall_e, stall_m;
   logic        flush_d, flush_e, flush_w;
   logic [1:0]  fwd_a, fwd_b;
   logic        mem_to;
   logic [31:0] stall_cyc, flush_cnt;
   logic [6:0]  ctl;

   int checks = 0;
   int errors = 0;

   // Model of the memory-wait history: consecutive stalled cycles and error
   int m_stalled = 0;
   bit m_err     = 1'b0;
   bit m_to      = 1'b0;
   int m_stall_total = 0;
   int m_flush_total = 0;

   hazard_sequencer #(
      .LOAD_RESULT_SRC (3'b001),
      .MEM_TIMEOUT     (TB_TIMEOUT)
   ) dut (
      .iClk         (clk),
      .iRst         (rst),
      .iRs1D        (rs1_d),
      .iRs2D        (rs2_d),
      .iRs1E        (rs1_e),
      .iRs2E        (rs2_e),
      .iRdE         (rd_e),
      .iResultSrcE  (res_src_e),
      .iRegWriteEnE (we_e),
      .iPCSrcE      (pcsrc_e),
      .iRdM         (rd_m),
      .iRegWriteEnM (we_m),
      .iMemReqM     (req_m),
      .iMemReadyM   (rdy_m),
      .iRdW         (rd_w),
      .iRegWriteEnW (we_w),
      .oStallF      (stall_f),
      .oStallD      (stall_d),
      .oStallE      (stall_e),
      .oStallM      (stall_m),
      .oFlushD      (flush_d),
      .oFlushE      (flush_e),
      .oFlushW      (flush_w),
      .oForwardAE   (fwd_a),
      .oForwardBE   (fwd_b),
      .oMemTimeout  (mem_to),
      .oStallCycles (stall_cyc),
      .oFlushCount  (flush_cnt)
   );

   always #5 clk = ~clk;

   assign ctl = {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [1:0] fwd_rule(input logic [4:0] rs);
      if (we_m && rd_m != 0 && rd_m == rs) return 2'b10;
      if (we_w && rd_w != 0 && rd_w == rs) return 2'b01;
      return 2'b00;
   endfunction

   // Per-cycle comparison against the model, then advance the model
   initial begin
      @(posedge clk);
      forever begin
         logic [6:0] e_ctl;
         bit mem_stall, release_c, load_use;
         @(negedge clk);
         load_use  = (res_src_e == 3'b001) && we_e && rd_e != 0 &&
                     (rd_e == rs1_d || rd_e == rs2_d);
         mem_stall = m_err || (m_stalled > 0 ? !rdy_m : (req_m && !rdy_m));
         release_c = !m_err && m_stalled > 0 && rdy_m;
         if (rst)            e_ctl = 7'b0000110;
         else if (mem_stall) e_ctl = 7'b1111001;
         else if (release_c) e_ctl = 7'b0000000;
         else if (pcsrc_e)   e_ctl = 7'b0000110;
         else if (load_use)  e_ctl = 7'b1100010;
         else                e_ctl = 7'b0000000;
         chk("model_ctl", {25'd0, ctl}, {25'd0, e_ctl});
         chk("model_fwd_a", {30'd0, fwd_a}, rst ? 32'd0 : {30'd0, fwd_rule(rs1_e)});
         chk("model_fwd_b", {30'd0, fwd_b}, rst ? 32'd0 : {30'd0, fwd_rule(rs2_e)});
         chk("model_timeout", {31'd0, mem_to}, {31'd0, m_to});
`ifdef HAZARD_PERF_CNT_EN
         chk("model_stall_cycles", stall_cyc, m_stall_total);
         chk("model_flush_count", flush_cnt, m_flush_total);
`else
         chk("model_stall_cycles", stall_cyc, 32'd0);
         chk("model_flush_count", flush_cnt, 32'd0);
`endif
         if (rst) begin
            m_stalled = 0; m_err = 0; m_to = 0;
            m_stall_total = 0; m_flush_total = 0;
         end else begin
            if (e_ctl[6]) m_stall_total++;
            if (e_ctl[1]) m_flush_total++;
            if (!m_err) begin
               if (mem_stall) begin
                  m_stalled++;
                  if (m_stalled >= TB_TIMEOUT) begin m_err = 1; m_to = 1; end
               end else begin
                  m_stalled = 0;
               end
            end
         end
      end
   end

   task automatic idle();
      rs1_d = 0; rs2_d = 0; rs1_e = 0; rs2_e = 0; rd_e = 0; rd_m = 0; rd_w = 0;
      res_src_e = 0; we_e = 0; pcsrc_e = 0; we_m = 0; req_m = 0; rdy_m = 0; we_w = 0;
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic load_use_hz(input logic [4:0] rd);
      res_src_e = 3'b001; we_e = 1; rd_e = rd; rs1_d = 5;
   endtask

   task automatic do_reset();
      idle(); rst = 1; cyc(); rst = 0;
   endtask

   initial begin
      rst = 1; idle();
      @(negedge clk);
      chk("rst_ctl", {25'd0, ctl}, 32'h06);
      cyc();
      @(negedge clk);
      chk("rst_timeout", {31'd0, mem_to}, 32'd0);
      chk("rst_stall_cycles", stall_cyc, 32'd0);
      cyc(); rst = 0;
      @(negedge clk); chk("idle_ctl", {25'd0, ctl}, 32'd0); cyc();

      // Load-use on rs1, bubble next cycle, then rd=0 and non-load variants
      load_use_hz(5);
      @(negedge clk); chk("load_use_ctl", {25'd0, ctl}, 32'h62); cyc();
      we_e = 0;
      @(negedge clk); chk("load_use_one_cycle", {25'd0, ctl}, 32'd0); cyc();
      load_use_hz(0);
      @(negedge clk); chk("load_use_rd0", {25'd0, ctl}, 32'd0); cyc();
      idle(); res_src_e = 3'b001; we_e = 1; rd_e = 9; rs1_d = 1; rs2_d = 9;
      @(negedge clk); chk("load_use_rs2", {25'd0, ctl}, 32'h62); cyc();
      res_src_e = 3'b010;
      @(negedge clk); chk("non_load_no_stall", {25'd0, ctl}, 32'd0); cyc();

      // Forwarding priority
      idle(); rd_m = 7; rd_w = 7; we_m = 1; we_w = 1; rs1_e = 7;
      @(negedge clk); chk("fwd_a_mem", {30'd0, fwd_a}, 32'd2); cyc();
      we_m = 0;
      @(negedge clk); chk("fwd_a_wb", {30'd0, fwd_a}, 32'd1); cyc();
      rs2_e = 7;
      @(negedge clk); chk("fwd_b_wb", {30'd0, fwd_b}, 32'd1); cyc();
      we_m = 1;
      @(negedge clk); chk("fwd_b_mem", {30'd0, fwd_b}, 32'd2); cyc();
      rd_m = 0;
      @(negedge clk); chk("fwd_b_rdm0", {30'd0, fwd_b}, 32'd1); cyc();
      rd_w = 0; we_w = 1;
      @(negedge clk); chk("fwd_a_none", {30'd0, fwd_a}, 32'd0); cyc();

      // Branch beats load-use
      do_reset();
      load_use_hz(5); pcsrc_e = 1;
      @(negedge clk); chk("branch_vs_lu", {25'd0, ctl}, 32'h06); cyc();
      idle();
      @(negedge clk);
`ifdef HAZARD_PERF_CNT_EN
      chk("branch_flush_count", flush_cnt, 32'd1);
`else
      chk("branch_flush_count", flush_cnt, 32'd0);
`endif
      cyc();

      // Memory wait of 3 cycles with a branch held in E
      do_reset();
      req_m = 1; rdy_m = 0; pcsrc_e = 1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); chk("mem_wait_ctl", {25'd0, ctl}, 32'h79); cyc();
      end
      rdy_m = 1;
      @(negedge clk); chk("mem_release_ctl", {25'd0, ctl}, 32'd0); cyc();
      req_m = 0; rdy_m = 0;
      @(negedge clk); chk("post_release_branch", {25'd0, ctl}, 32'h06);
`ifdef HAZARD_PERF_CNT_EN
      chk("mem_stall_cycles", stall_cyc, 32'd3);
`else
      chk("mem_stall_cycles", stall_cyc, 32'd0);
`endif
      cyc();

      // First-cycle ready: no stall, branch still applies
      idle(); req_m = 1; rdy_m = 1; pcsrc_e = 1;
      @(negedge clk); chk("ready_first_cycle", {25'd0, ctl}, 32'h06); cyc();

      // Ready on the 4th wait cycle: no timeout, release hides load-use
      do_reset();
      req_m = 1; rdy_m = 0;
      repeat (3) cyc();
      rdy_m = 1; load_use_hz(5);
      @(negedge clk); chk("release_at_limit", {25'd0, ctl}, 32'd0); cyc();
      idle();
      @(negedge clk); chk("no_timeout_at_limit", {31'd0, mem_to}, 32'd0); cyc();

      // Timeout after 4 stalled cycles, held until reset
      do_reset();
      req_m = 1; rdy_m = 0;
      repeat (4) cyc();
      req_m = 0; rdy_m = 1;
      @(negedge clk);
      chk("timeout_flag", {31'd0, mem_to}, 32'd1);
      chk("timeout_stalls", {25'd0, ctl}, 32'h79);
      cyc(); cyc();
      @(negedge clk); chk("error_sticky", {25'd0, ctl}, 32'h79); cyc();
      rst = 1;
      @(negedge clk); chk("error_rst_ctl", {25'd0, ctl}, 32'h06); cyc();
      rst = 0; idle();
      @(negedge clk);
      chk("post_rst_timeout", {31'd0, mem_to}, 32'd0);
      chk("post_rst_ctl", {25'd0, ctl}, 32'd0);
      chk("post_rst_stall_cycles", stall_cyc, 32'd0);
      cyc();
      @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
